// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding, minimum data length
// and the expected-parity function also used by the TX parity generator.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP1  = 3'd3,
        ST_STOP2  = 3'd4
    } rx_state_t;

    localparam int DATA_BITS_MIN = 5;

    // Widest data word the parity function accepts; narrower words are
    // zero-extended by the caller, which leaves the XOR unchanged.
    localparam int PARITY_DATA_W = 16;

    // Expected parity bit. Stick parity forces the bit to ~eps; otherwise
    // even parity (eps=1) makes data+parity carry an even number of ones.
    function automatic logic parity_expected(input logic [PARITY_DATA_W-1:0] data,
                                             input logic                      eps,
                                             input logic                      sp);
        logic result;
        if (sp) begin
            result = ~eps;
        end else if (eps) begin
            result = ^data;
        end else begin
            result = ~(^data);
        end
        return result;
    endfunction

endpackage

// File: rtl/counter_en.sv
// Generic up-counter with synchronous clear (priority) and count enable.
module counter_en #(
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    output logic [COUNTER_WIDTH-1:0] count
);

    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] count_d;

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + COUNTER_WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uart_rx_frame_sequencer.sv
// Receive-frame sequencer: walks data / parity / stop bit positions on
// mid-bit sample strobes, assembles the word LSB-first, checks parity and
// stop bits, detects break and emits one registered completion pulse.
//
// Handshake: start_valid and sample_edge are single-cycle strobes with no
// back-pressure; start_valid is only taken in IDLE, sample_edge only outside
// IDLE, and receive_done is a one-cycle pulse with results valid alongside.
module uart_rx_frame_sequencer
    import uart_rx_pkg::*;
#(
    parameter int MAX_DATA_BITS = 8,
    parameter int DB_W          = $clog2(MAX_DATA_BITS + 1)
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     start_valid,
    input  logic                     sample_edge,
    input  logic                     rx_bit,
    input  logic                     abort,
    input  logic [DB_W-1:0]          data_bits,
    input  logic                     pen,
    input  logic                     eps,
    input  logic                     sp,
    input  logic                     stb,
    output logic                     busy,
    output logic [DB_W-1:0]          bit_idx,
    output logic                     receive_done,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     break_det,
    output logic [2:0]               dbg_state
);

    rx_state_t state_q, state_d;

    // Configuration captured at start_valid.
    logic [DB_W-1:0] n_q, n_d;
    logic            pen_q, pen_d;
    logic            eps_q, eps_d;
    logic            sp_q, sp_d;
    logic            stb_q, stb_d;

    // In-flight frame accumulators.
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                     perr_acc_q, perr_acc_d;
    logic                     ferr_acc_q, ferr_acc_d;
    logic                     any_one_q, any_one_d;

    // Published results.
    logic                     done_q, done_d;
    logic [MAX_DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                     parity_err_q, parity_err_d;
    logic                     frame_err_q, frame_err_d;
    logic                     break_det_q, break_det_d;

    logic [DB_W-1:0]          n_cfg;
    logic [PARITY_DATA_W-1:0] par_in;
    logic                     cnt_clear;
    logic                     cnt_en;
    logic                     last_data;

    // Clamp the requested data length into the supported range.
    always_comb begin
        n_cfg = data_bits;
        if (data_bits < DB_W'(DATA_BITS_MIN)) begin
            n_cfg = DB_W'(DATA_BITS_MIN);
        end else if (data_bits > DB_W'(MAX_DATA_BITS)) begin
            n_cfg = DB_W'(MAX_DATA_BITS);
        end
    end

    // Zero-extend the assembled word for the shared parity function.
    always_comb begin
        par_in = '0;
        par_in[MAX_DATA_BITS-1:0] = shift_q;
    end

    assign cnt_clear = ((state_q == ST_IDLE) && start_valid) || abort;
    assign cnt_en    = (state_q == ST_DATA) && sample_edge && !abort;
    assign last_data = (bit_idx == (n_q - DB_W'(1)));

    counter_en #(
        .COUNTER_WIDTH(DB_W)
    ) u_bit_cnt (
        .clk  (pclk),
        .rst  (preset),
        .clear(cnt_clear),
        .en   (cnt_en),
        .count(bit_idx)
    );

    // Next-state, accumulation and result update; abort overrides last.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        pen_d        = pen_q;
        eps_d        = eps_q;
        sp_d         = sp_q;
        stb_d        = stb_q;
        shift_d      = shift_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        any_one_d    = any_one_q;
        done_d       = 1'b0;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    n_d        = n_cfg;
                    pen_d      = pen;
                    eps_d      = eps;
                    sp_d       = sp;
                    stb_d      = stb;
                    shift_d    = '0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                    any_one_d  = 1'b0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_edge) begin
                    for (int i = 0; i < MAX_DATA_BITS; i++) begin
                        if (bit_idx == DB_W'(i)) begin
                            shift_d[i] = rx_bit;
                        end
                    end
                    any_one_d = any_one_q | rx_bit;
                    if (last_data) begin
                        state_d = pen_q ? ST_PARITY : ST_STOP1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_edge) begin
                    perr_acc_d = (rx_bit != parity_expected(par_in, eps_q, sp_q));
                    any_one_d  = any_one_q | rx_bit;
                    state_d    = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (sample_edge) begin
                    if (stb_q) begin
                        ferr_acc_d = ferr_acc_q | ~rx_bit;
                        any_one_d  = any_one_q | rx_bit;
                        state_d    = ST_STOP2;
                    end else begin
                        done_d       = 1'b1;
                        rx_data_d    = shift_q;
                        parity_err_d = perr_acc_q;
                        frame_err_d  = ferr_acc_q | ~rx_bit;
                        break_det_d  = ~(any_one_q | rx_bit);
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (sample_edge) begin
                    done_d       = 1'b1;
                    rx_data_d    = shift_q;
                    parity_err_d = perr_acc_q;
                    frame_err_d  = ferr_acc_q | ~rx_bit;
                    break_det_d  = ~(any_one_q | rx_bit);
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d      = ST_IDLE;
            done_d       = 1'b0;
            rx_data_d    = rx_data_q;
            parity_err_d = parity_err_q;
            frame_err_d  = frame_err_q;
            break_det_d  = break_det_q;
        end
    end

    // State, configuration, accumulator and result registers.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= ST_IDLE;
            n_q          <= DB_W'(DATA_BITS_MIN);
            pen_q        <= 1'b0;
            eps_q        <= 1'b0;
            sp_q         <= 1'b0;
            stb_q        <= 1'b0;
            shift_q      <= '0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            any_one_q    <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            pen_q        <= pen_d;
            eps_q        <= eps_d;
            sp_q         <= sp_d;
            stb_q        <= stb_d;
            shift_q      <= shift_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            any_one_q    <= any_one_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign receive_done = done_q;
    assign rx_data      = rx_data_q;
    assign parity_err   = parity_err_q;
    assign frame_err    = frame_err_q;
    assign break_det    = break_det_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_rx_frame_sequencer.sv
// Directed bench for uart_rx_frame_sequencer (MAX_DATA_BITS = 12).
module tb_uart_rx_frame_sequencer;

    localparam int MAXB = 12;
    localparam int DBW  = 4;

    logic            pclk;
    logic            preset;
    logic            start_valid;
    logic            sample_edge;
    logic            rx_bit;
    logic            abort;
    logic [DBW-1:0]  data_bits;
    logic            pen;
    logic            eps;
    logic            sp;
    logic            stb;
    logic            busy;
    logic [DBW-1:0]  bit_idx;
    logic            receive_done;
    logic [MAXB-1:0] rx_data;
    logic            parity_err;
    logic            frame_err;
    logic            break_det;
    logic [2:0]      dbg_state;

    int errors = 0;
    int checks = 0;

    uart_rx_frame_sequencer #(
        .MAX_DATA_BITS(MAXB),
        .DB_W         (DBW)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .start_valid (start_valid),
        .sample_edge (sample_edge),
        .rx_bit      (rx_bit),
        .abort       (abort),
        .data_bits   (data_bits),
        .pen         (pen),
        .eps         (eps),
        .sp          (sp),
        .stb         (stb),
        .busy        (busy),
        .bit_idx     (bit_idx),
        .receive_done(receive_done),
        .rx_data     (rx_data),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .break_det   (break_det),
        .dbg_state   (dbg_state)
    );

    // Clock.
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // One cycle of stimulus; returns 1 time unit after the capturing edge.
    task automatic drive(input logic sv, input logic se, input logic b);
        start_valid = sv;
        sample_edge = se;
        rx_bit      = b;
        @(posedge pclk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Start a frame (with a coincident, to-be-ignored sample_edge), scramble
    // the config pins afterwards, then send len sample bits from seq (LSB
    // first). early is set if done fires or busy drops before the last bit.
    task automatic run_frame(input logic [DBW-1:0] db, input logic p, input logic e,
                             input logic s, input logic t, input logic [31:0] seq,
                             input int len, output logic early);
        early     = 1'b0;
        data_bits = db;
        pen       = p;
        eps       = e;
        sp        = s;
        stb       = t;
        drive(1'b1, 1'b1, 1'b1);
        data_bits = 4'd5;
        pen       = ~p;
        eps       = ~e;
        sp        = ~s;
        stb       = ~t;
        for (int i = 0; i < len; i++) begin
            drive(1'b0, 1'b1, seq[i]);
            if (i < len - 1 && (receive_done !== 1'b0 || busy !== 1'b1)) early = 1'b1;
        end
    endtask

    task automatic test_reset();
        preset      = 1'b1;
        start_valid = 1'b0;
        sample_edge = 1'b0;
        rx_bit      = 1'b0;
        abort       = 1'b0;
        data_bits   = 4'd8;
        pen         = 1'b0;
        eps         = 1'b0;
        sp          = 1'b0;
        stb         = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        preset = 1'b0;
        idle();
        checks++;
        if ({busy, receive_done, parity_err, frame_err, break_det} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {busy, receive_done, parity_err, frame_err, break_det});
        end
        checks++;
        if (rx_data !== 12'h000 || bit_idx !== 4'd0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_values rx_data=%h bit_idx=%0d state=%0d exp 000/0/0",
                     rx_data, bit_idx, dbg_state);
        end
    endtask

    task automatic test_8n1();
        logic early;
        run_frame(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1A5, 9, early);
        checks++;
        if (early !== 1'b0 || receive_done !== 1'b1) begin
            errors++;
            $display("FAIL 8n1_done_timing early=%b done=%b exp early=0 done=1", early, receive_done);
        end
        checks++;
        if (rx_data !== 12'h0A5 || {parity_err, frame_err, break_det} !== 3'b000) begin
            errors++;
            $display("FAIL 8n1_result rx_data=%h flags=%b exp 0a5/000",
                     rx_data, {parity_err, frame_err, break_det});
        end
        checks++;
        if (bit_idx !== 4'd8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_idx_busy bit_idx=%0d busy=%b exp 8/0", bit_idx, busy);
        end
        idle();
        checks++;
        if (receive_done !== 1'b0 || rx_data !== 12'h0A5) begin
            errors++;
            $display("FAIL 8n1_hold done=%b rx_data=%h exp 0/0a5", receive_done, rx_data);
        end
    endtask

    task automatic test_7e2();
        logic early;
        // 0x35 in 7 bits has four ones: even parity bit is 0.
        run_frame(4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h335, 10, early);
        checks++;
        if (early !== 1'b0 || receive_done !== 1'b1 || parity_err !== 1'b0 ||
            rx_data !== 12'h035 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL 7e2_par_ok early=%b done=%b perr=%b ferr=%b rx=%h exp 0/1/0/0/035",
                     early, receive_done, parity_err, frame_err, rx_data);
        end
        idle();
        run_frame(4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3B5, 10, early);
        checks++;
        if (early !== 1'b0 || receive_done !== 1'b1 || parity_err !== 1'b1 || rx_data !== 12'h035) begin
            errors++;
            $display("FAIL 7e2_par_bad early=%b done=%b perr=%b rx=%h exp 0/1/1/035",
                     early, receive_done, parity_err, rx_data);
        end
        idle();
    endtask

    task automatic test_stick_clamp_low();
        logic early;
        // data_bits=3 clamps to 5; stick with eps=1 expects parity bit 0.
        run_frame(4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h76, 7, early);
        checks++;
        if (early !== 1'b0 || receive_done !== 1'b1 || parity_err !== 1'b1 || rx_data !== 12'h016) begin
            errors++;
            $display("FAIL stick_bad early=%b done=%b perr=%b rx=%h exp 0/1/1/016",
                     early, receive_done, parity_err, rx_data);
        end
        idle();
        run_frame(4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h56, 7, early);
        checks++;
        if (early !== 1'b0 || receive_done !== 1'b1 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL stick_ok early=%b done=%b perr=%b exp 0/1/0", early, receive_done, parity_err);
        end
        idle();
    endtask

    task automatic test_max_width();
        logic early;
        // 12 data bits, two stop bits, second stop bit 0.
        run_frame(4'd12, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1ABC, 14, early);
        checks++;
        if (early !== 1'b0 || receive_done !== 1'b1 || rx_data !== 12'hABC ||
            {parity_err, frame_err, break_det} !== 3'b010) begin
            errors++;
            $display("FAIL max12_frame_err early=%b done=%b rx=%h flags=%b exp 0/1/abc/010",
                     early, receive_done, rx_data, {parity_err, frame_err, break_det});
        end
        idle();
        // data_bits=15 clamps to 12.
        run_frame(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1FFF, 13, early);
        checks++;
        if (early !== 1'b0 || receive_done !== 1'b1 || rx_data !== 12'hFFF || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL clamp_high early=%b done=%b rx=%h ferr=%b exp 0/1/fff/0",
                     early, receive_done, rx_data, frame_err);
        end
        idle();
    endtask

    task automatic test_break();
        logic early;
        run_frame(4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 10, early);
        checks++;
        if (early !== 1'b0 || receive_done !== 1'b1 || rx_data !== 12'h000 ||
            {parity_err, frame_err, break_det} !== 3'b011) begin
            errors++;
            $display("FAIL break early=%b done=%b rx=%h flags=%b exp 0/1/000/011",
                     early, receive_done, rx_data, {parity_err, frame_err, break_det});
        end
        idle();
    endtask

    task automatic test_abort();
        logic saw_done;
        data_bits = 4'd8;
        pen       = 1'b0;
        stb       = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1 || dbg_state !== 3'd1) begin
            errors++;
            $display("FAIL busy_rise busy=%b state=%0d exp 1/1", busy, dbg_state);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1);
        abort = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || receive_done !== 1'b0 || bit_idx !== 4'd0) begin
            errors++;
            $display("FAIL abort_drop busy=%b done=%b idx=%0d exp 0/0/0", busy, receive_done, bit_idx);
        end
        // Further sample edges in IDLE must do nothing.
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, i[0]);
            if (receive_done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0 || rx_data !== 12'h000 ||
            {parity_err, frame_err, break_det} !== 3'b011) begin
            errors++;
            $display("FAIL abort_retain activity=%b rx=%h flags=%b exp 0/000/011",
                     saw_done, rx_data, {parity_err, frame_err, break_det});
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic early;
        run_frame(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h15A, 9, early);
        checks++;
        if (early !== 1'b0 || receive_done !== 1'b1 || rx_data !== 12'h05A) begin
            errors++;
            $display("FAIL b2b_first early=%b done=%b rx=%h exp 0/1/05a", early, receive_done, rx_data);
        end
        // The next start_valid lands in the same cycle as receive_done.
        run_frame(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h13C, 9, early);
        checks++;
        if (early !== 1'b0 || receive_done !== 1'b1 || rx_data !== 12'h03C ||
            {parity_err, frame_err, break_det} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_second early=%b done=%b rx=%h flags=%b exp 0/1/03c/000",
                     early, receive_done, rx_data, {parity_err, frame_err, break_det});
        end
        idle();
        checks++;
        if (receive_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse_width done=%b busy=%b exp 0/0", receive_done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_stick_clamp_low();
        test_max_width();
        test_break();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
